// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared defaults and state encoding for the per-port round-robin drain
// arbiter. SIZE_DEF matches the router FIFO item width; NUM_IN_DEF is the
// number of input FIFOs feeding one router output port.
package fifo_rr_arbiter_pkg;

   localparam int SIZE_DEF      = 2;
   localparam int NUM_IN_DEF    = 4;
   localparam int MAX_BURST_DEF = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } arb_state_t;

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational rotate-priority encoder.
// Finds the first set bit of i_req, searching i_start, i_start+1, ... modulo
// NUM_IN.
//   i_req   [NUM_IN]  request vector (input FIFO non-empty)
//   i_start [ID_W]    index searched first
//   o_valid           at least one request is set
//   o_idx   [ID_W]    winning index (0 when o_valid is low)
module fifo_rr_arbiter_rr_pick #(
   parameter int NUM_IN = 4,
   parameter int ID_W   = $clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] i_req,
   input  logic [ID_W-1:0]   i_start,
   output logic              o_valid,
   output logic [ID_W-1:0]   o_idx
);

   int              w_pos;
   logic [ID_W-1:0] w_j;

   // Walk offsets from farthest to nearest so the last hit, which wins, is the
   // one closest to i_start.
   always_comb begin
      o_valid = 1'b0;
      o_idx   = '0;
      w_pos   = 0;
      w_j     = '0;
      for (int k = NUM_IN - 1; k >= 0; k--) begin
         w_pos = int'(i_start) + k;
         if (w_pos >= NUM_IN) w_pos = w_pos - NUM_IN;
         w_j = ID_W'(w_pos);
         if (i_req[w_j]) begin
            o_valid = 1'b1;
            o_idx   = w_j;
         end
      end
   end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter draining NUM_IN upstream FIFOs into one downstream FIFO
// write port, with bounded bursts of up to MAX_BURST items per grant.
//   i_clk, i_reset            clock, async active-high reset
//   i_empty    [NUM_IN]       empty flags of the input FIFOs
//   i_item_in  [NUM_IN*SIZE]  head items, input i at [i*SIZE +: SIZE]
//   o_read     [NUM_IN]       pop strobes, zero or one-hot, combinational
//   i_out_full                full flag of the downstream FIFO
//   o_write                   push strobe (output-register valid)
//   o_item_out [SIZE]         item presented downstream
//   o_grant_id [ID_W]         source index of o_item_out
//   o_busy                    burst grant held
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no grant held; next selection is a pure rotate from r_cur+1
// ST_BURST | r_cur holds the grant; it keeps it while non-empty and the
//          | burst count is below MAX_BURST
module fifo_rr_arbiter
   import fifo_rr_arbiter_pkg::*;
#(
   parameter int NUM_IN    = NUM_IN_DEF,
   parameter int SIZE      = SIZE_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF,
   parameter int ID_W      = $clog2(NUM_IN)
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [NUM_IN-1:0]      i_empty,
   input  logic [NUM_IN*SIZE-1:0] i_item_in,
   output logic [NUM_IN-1:0]      o_read,
   input  logic                   i_out_full,
   output logic                   o_write,
   output logic [SIZE-1:0]        o_item_out,
   output logic [ID_W-1:0]        o_grant_id,
   output logic                   o_busy
);

   localparam int              CNT_W     = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
   localparam logic [ID_W-1:0]  LAST_IDX  = ID_W'(NUM_IN - 1);

   arb_state_t       r_state, w_state_nxt;
   logic [ID_W-1:0]  r_cur, w_cur_nxt;
   logic [CNT_W-1:0] r_burst_cnt, w_burst_cnt_nxt;
   logic             r_write, w_write_nxt;
   logic [SIZE-1:0]  r_item, w_item_nxt;
   logic [ID_W-1:0]  r_grant_id, w_grant_id_nxt;

   logic [NUM_IN-1:0] w_req;
   logic [ID_W-1:0]   w_start;
   logic [ID_W-1:0]   w_pick_idx;
   logic              w_pick_valid;
   logic [ID_W-1:0]   w_sel;
   logic              w_sel_valid;
   logic [SIZE-1:0]   w_sel_item;
   logic              w_hold;
   logic              w_can_issue;
   logic              w_any_req;
   logic              w_issue;

   assign w_req     = ~i_empty;
   assign w_any_req = |w_req;

   // Output register is free, or its item leaves on this edge.
   assign w_can_issue = ~r_write | ~i_out_full;

   // Rotation starts just past the last grant; explicit wrap keeps this
   // correct for NUM_IN that is not a power of two.
   assign w_start = (r_cur == LAST_IDX) ? '0 : r_cur + 1'b1;

   fifo_rr_arbiter_rr_pick #(
      .NUM_IN (NUM_IN),
      .ID_W   (ID_W)
   ) u_rr_pick (
      .i_req   (w_req),
      .i_start (w_start),
      .o_valid (w_pick_valid),
      .o_idx   (w_pick_idx)
   );

   assign w_hold      = (r_state == ST_BURST) && w_req[r_cur] && (r_burst_cnt < BURST_LIM);
   assign w_sel       = w_hold ? r_cur : w_pick_idx;
   assign w_sel_valid = w_hold | w_pick_valid;
   assign w_issue     = w_can_issue & w_sel_valid & ~i_reset;

   always_comb begin
      w_sel_item = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (w_sel == ID_W'(i)) w_sel_item = i_item_in[i*SIZE +: SIZE];
      end
   end

   // State register (also carries the datapath registers it sequences).
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_cur       <= LAST_IDX;
         r_burst_cnt <= '0;
         r_write     <= 1'b0;
         r_item      <= '0;
         r_grant_id  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cur       <= w_cur_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
         r_write     <= w_write_nxt;
         r_item      <= w_item_nxt;
         r_grant_id  <= w_grant_id_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt     = r_state;
      w_cur_nxt       = r_cur;
      w_burst_cnt_nxt = r_burst_cnt;
      w_write_nxt     = r_write;
      w_item_nxt      = r_item;
      w_grant_id_nxt  = r_grant_id;
      if (w_issue) begin
         w_state_nxt     = ST_BURST;
         w_cur_nxt       = w_sel;
         w_write_nxt     = 1'b1;
         w_item_nxt      = w_sel_item;
         w_grant_id_nxt  = w_sel;
         // A rotate that lands back on r_cur (lone requester) restarts the burst.
         w_burst_cnt_nxt = w_hold ? r_burst_cnt + 1'b1 : CNT_W'(1);
      end else begin
         if (!i_out_full) w_write_nxt = 1'b0;
         if (w_can_issue && !w_any_req) begin
            w_state_nxt     = ST_IDLE;
            w_burst_cnt_nxt = '0;
         end
      end
   end

   // Outputs.
   always_comb begin
      o_read = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         o_read[i] = w_issue && (w_sel == ID_W'(i));
      end
      o_busy = (r_state == ST_BURST);
   end

   assign o_write    = r_write;
   assign o_item_out = r_item;
   assign o_grant_id = r_grant_id;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
module tb_fifo_rr_arbiter;

   logic       clk_sys = 1'b0;
   logic       rst     = 1'b1;

   // three instances: [0] MAX_BURST=4, [1] MAX_BURST=1, [2] MAX_BURST=2
   logic [3:0] tb_empty [3];
   logic [7:0] tb_item  [3];
   logic [3:0] tb_rd    [3];
   logic       tb_full  [3];
   logic       tb_wr    [3];
   logic [1:0] tb_iout  [3];
   logic [1:0] tb_gid   [3];
   logic       tb_busy  [3];

   int cnt  [3][4];
   int pops [3][4];
   int outp [3][4];

   int eg  [16];
   int ebc [16];

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk_sys = ~clk_sys;

   // input FIFO model: head item of input i after n pops is (i+n) mod 4
   always_comb begin
      for (int d = 0; d < 3; d++) begin
         for (int i = 0; i < 4; i++) begin
            tb_empty[d][i]       = (cnt[d][i] == 0);
            tb_item[d][i*2 +: 2] = 2'((i + pops[d][i]) % 4);
         end
      end
   end

   fifo_rr_arbiter #(.NUM_IN(4), .SIZE(2), .MAX_BURST(4)) u_dut_b4 (
      .i_clk(clk_sys), .i_reset(rst), .i_empty(tb_empty[0]), .i_item_in(tb_item[0]),
      .o_read(tb_rd[0]), .i_out_full(tb_full[0]), .o_write(tb_wr[0]),
      .o_item_out(tb_iout[0]), .o_grant_id(tb_gid[0]), .o_busy(tb_busy[0]));

   fifo_rr_arbiter #(.NUM_IN(4), .SIZE(2), .MAX_BURST(1)) u_dut_b1 (
      .i_clk(clk_sys), .i_reset(rst), .i_empty(tb_empty[1]), .i_item_in(tb_item[1]),
      .o_read(tb_rd[1]), .i_out_full(tb_full[1]), .o_write(tb_wr[1]),
      .o_item_out(tb_iout[1]), .o_grant_id(tb_gid[1]), .o_busy(tb_busy[1]));

   fifo_rr_arbiter #(.NUM_IN(4), .SIZE(2), .MAX_BURST(2)) u_dut_b2 (
      .i_clk(clk_sys), .i_reset(rst), .i_empty(tb_empty[2]), .i_item_in(tb_item[2]),
      .o_read(tb_rd[2]), .i_out_full(tb_full[2]), .o_write(tb_wr[2]),
      .o_item_out(tb_iout[2]), .o_grant_id(tb_gid[2]), .o_busy(tb_busy[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // latch pops before the edge, apply them to the model just after it
   task automatic cycle_end();
      logic [3:0] r [3];
      for (int d = 0; d < 3; d++) r[d] = tb_rd[d];
      @(posedge clk_sys);
      #1;
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 4; i++)
            if (r[d][i]) begin
               cnt[d][i]--;
               pops[d][i]++;
            end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         tb_full[d] = 1'b0;
         for (int i = 0; i < 4; i++) begin
            cnt[d][i]  = 0;
            pops[d][i] = 0;
            outp[d][i] = 0;
         end
      end
      @(posedge clk_sys); #1;
      @(posedge clk_sys); #1;
      rst = 1'b0;
      #1;
   endtask

   // run instance d until drained; eg[0:n-1] is the expected grant order
   task automatic drain(input int d, input int n, input logic [31:0] full_mask);
      int  ncons = 0;
      bit  done  = 0;
      bit  any_req;
      bit  can;
      int  g;
      for (int cyc = 0; cyc < 60; cyc++) begin
         tb_full[d] = (cyc < 32) ? full_mask[cyc] : 1'b0;
         @(negedge clk_sys);
         any_req = (tb_empty[d] != 4'hF);
         can     = !tb_wr[d] || !tb_full[d];
         if (can && any_req) chk("rd_onehot", 32'($countones(tb_rd[d])), 1);
         else                chk("rd_idle", 32'(tb_rd[d]), 0);
         if (tb_wr[d]) begin
            if (ncons < n) begin
               g = eg[ncons];
               chk("grant_id", 32'(tb_gid[d]), g);
               chk("item_out", 32'(tb_iout[d]), (g + outp[d][g]) % 4);
               chk("busy_hi", 32'(tb_busy[d]), 1);
               if (d == 2) chk("burst_cnt", 32'(u_dut_b2.r_burst_cnt), ebc[ncons]);
               if (!tb_full[d]) outp[d][g]++;
            end else begin
               chk("extra_write", 1, 0);
            end
            if (!tb_full[d]) ncons++;
         end
         if (!any_req && !tb_wr[d]) begin
            done = 1;
            break;
         end
         cycle_end();
      end
      chk("drain_done", 32'(done), 1);
      chk("write_count", ncons, n);
      chk("busy_lo", 32'(tb_busy[d]), 0);
      tb_full[d] = 1'b0;
      @(posedge clk_sys); #1;
   endtask

   initial begin
      for (int d = 0; d < 3; d++) tb_full[d] = 1'b0;
      do_reset();

      // reset state and first grant
      for (int d = 0; d < 3; d++) begin
         chk("rst_write", 32'(tb_wr[d]), 0);
         chk("rst_busy", 32'(tb_busy[d]), 0);
         chk("rst_item", 32'(tb_iout[d]), 0);
         chk("rst_gid", 32'(tb_gid[d]), 0);
         chk("rst_read", 32'(tb_rd[d]), 0);
      end
      @(negedge clk_sys);
      chk("empty_read", 32'(tb_rd[0]), 0);
      chk("empty_write", 32'(tb_wr[0]), 0);
      @(posedge clk_sys); #1;
      cnt[0][1] = 1;
      #1;
      chk("first_read", 32'(tb_rd[0]), 32'h2);
      eg[0] = 1;
      drain(0, 1, 32'h0);

      // pure round robin with MAX_BURST=1
      do_reset();
      for (int i = 0; i < 4; i++) cnt[1][i] = 3;
      eg = '{0,1,2,3, 0,1,2,3, 0,1,2,3, 0,0,0,0};
      drain(1, 12, 32'h0);

      // burst limit with MAX_BURST=4
      do_reset();
      cnt[0][0] = 6;
      cnt[0][2] = 2;
      eg = '{0,0,0,0, 2,2,0,0, 0,0,0,0, 0,0,0,0};
      drain(0, 8, 32'h0);

      // downstream backpressure: full on cycles 1..3, then back-to-back refill
      do_reset();
      cnt[0][0] = 3;
      eg = '{0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,0};
      drain(0, 3, 32'h0000_000E);

      // lone requester at the wrap point, MAX_BURST=2
      do_reset();
      cnt[2][3] = 5;
      eg  = '{3,3,3,3,3, 0,0,0, 0,0,0,0, 0,0,0,0};
      ebc = '{1,2,1,2,1, 0,0,0, 0,0,0,0, 0,0,0,0};
      drain(2, 5, 32'h0);

      // reset mid-burst discards the in-flight item
      do_reset();
      cnt[0][0] = 4;
      cnt[0][1] = 4;
      #1;
      chk("mid_first_read", 32'(tb_rd[0]), 32'h1);
      cycle_end();
      chk("mid_write_before", 32'(tb_wr[0]), 1);
      rst = 1'b1;
      #1;
      chk("mid_write_rst", 32'(tb_wr[0]), 0);
      chk("mid_read_rst", 32'(tb_rd[0]), 0);
      @(negedge clk_sys);
      chk("mid_read_rst_neg", 32'(tb_rd[0]), 0);
      @(posedge clk_sys); #1;
      rst = 1'b0;
      #1;
      chk("mid_restart_read", 32'(tb_rd[0]), 32'h1);
      outp[0][0] = 1;
      eg = '{0,0,0,1, 1,1,1,0, 0,0,0,0, 0,0,0,0};
      drain(0, 7, 32'h0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Round-robin arbiter that drains up to `NUM_IN` upstream FIFOs onto one downstream FIFO write port. It is the per-output-port scheduler of a router:
- it issues `read` to one non-empty input FIFO per cycle and registers the popped item;
- it presents the item as a `write` to the output FIFO, honouring `full`;
- it supports bounded bursts: a granted input keeps the grant for up to `MAX_BURST` consecutive items before rotation.

## Interface
- `NUM_IN`, 4: number of input FIFOs; must be at least 2.
- `SIZE`, 2: item width in bits; matches the FIFO item width.
- `MAX_BURST`, 4: maximum consecutive grants to one input; must be at least 1.
- `ID_W`, `$clog2(NUM_IN)`: grant index width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `empty` in `NUM_IN`: `empty` flags of the input FIFOs.
- `item_in` in `NUM_IN*SIZE`: head items of the input FIFOs. Input i occupies `[i*SIZE +: SIZE]` and is valid in the same cycle (FIFO `item_out` is combinational).
- `read` out `NUM_IN`: pop strobes to the input FIFOs; zero or one-hot.
- `out_full` in 1: `full` flag of the downstream FIFO.
- `write` out 1: push strobe to the downstream FIFO; this is the output-register valid bit.
- `item_out` out `SIZE`: item presented to the downstream FIFO.
- `grant_id` out `ID_W`: source index of the item currently in `item_out`.
- `busy` out 1: high while a burst grant is held (state BURST).

## Operation
- Internal registers:
  - `state` ∈ {IDLE, BURST}
  - `cur` (`ID_W`), the last granted index
  - `burst_cnt` (width `$clog2(MAX_BURST+1)`)
  - the output register (`write`, `item_out`, `grant_id`)
- `can_issue = !write | !out_full`: the output register is empty or is draining this cycle.
- Selection, combinational:
  - **Hold:** if `state==BURST`, `!empty[cur]` and `burst_cnt < MAX_BURST`, then `sel = cur`.
  - **Rotate:** otherwise `sel` is the first i with `!empty[i]`, searching `cur+1, cur+2, …` mod `NUM_IN` and ending at `cur` itself. This is work-conserving: a lone requester is re-granted with `burst_cnt` restarted.
  - **None:** if all inputs are empty, there is no selection.
- `read[sel] = can_issue & selection_valid & !reset`; all other bits are 0.
- On a clock edge where a read is issued:
  - `item_out <= item_in[sel]`, `grant_id <= sel`, `write <= 1`, `cur <= sel`, `state <= BURST`.
  - `burst_cnt <= (sel==cur && hold taken) ? burst_cnt+1 : 1`.
- On a clock edge with no read:
  - If `!out_full`, then `write <= 0`.
  - If `can_issue` and no input is non-empty, then `state <= IDLE` and `burst_cnt <= 0`.
  - If stalled by `out_full` with `write` high, all registers hold and `read` stays 0.
- `write` only ever falls when the item is consumed (`!out_full`). An item is never dropped or duplicated.
- Reset values: `write=0`, `item_out=0`, `grant_id=0`, `busy=0`, `state=IDLE`, `cur=NUM_IN-1` (so the first search starts at input 0), `burst_cnt=0`. `read` is forced to 0 while `reset` is high.
- Reset mid-burst: the in-flight output item is discarded. Input FIFOs are not popped during reset.

## Timing
- `read` is combinational from `empty`, `out_full` and the registers; it has no registered latency.
- `item_out`/`write` appear in the cycle after the corresponding `read`.
- Throughput is 1 item per cycle while the downstream FIFO is not full. Input-to-output latency is 1 cycle.
- When `out_full` deasserts, the held item is written on that edge. A new `read` is issued in the same cycle, giving a back-to-back refill.
- Burst boundary:
  - After `MAX_BURST` consecutive grants to input k with others pending, the next grant goes to the next non-empty index after k.
  - With `MAX_BURST=1` this is pure round-robin.
- Simultaneous events:
  - A `read` and a downstream write in the same cycle are both legal.
  - A `read` on an input whose FIFO becomes empty after the pop causes the next selection to rotate.

## Structure
- A shared header/package holds the `SIZE` default (common with the FIFO), the `NUM_IN` default per router port, and the IDLE/BURST state encoding.
- Sub-module `rr_pick`: combinational rotate-priority encoder.
  - Inputs: `req[NUM_IN]`, `start` index.
  - Outputs: `valid`, `idx`.
  - Instantiated once, with `start = cur+1`. The hold path is evaluated outside it.

## Test plan
- **Reset and first grant.** With `NUM_IN=4`, `MAX_BURST=4`: reset, then `empty=4'b1111`, so `read=0` and `write=0`. Set `empty=4'b1101` (input 1 has items) → `read=4'b0010`; next cycle `write=1`, `grant_id=1`, `item_out` equals input 1's head.
- **Round-robin fairness.** `MAX_BURST=1`, all four inputs holding 3 items, `out_full=0` → grant order 0,1,2,3,0,1,2,3,0,1,2,3, one per cycle, 12 writes total.
- **Burst limit.** `MAX_BURST=4`, input 0 holding 6 items, input 2 holding 2 items → grants 0,0,0,0,2,2,0,0. `busy` stays high throughout and falls to 0 once every input is empty.
- **Downstream backpressure.** Hold `out_full=1` for 3 cycles while `write=1` → `read=0`, and `item_out`/`grant_id` are stable. On release, the held item is written and a new `read` fires in the same cycle; no loss or duplication is checked by a scoreboard.
- **Lone requester and wrap.** `cur=3`, only input 3 non-empty, `MAX_BURST=2`, 5 items → 5 consecutive grants to 3. `burst_cnt` goes 1,2,1,2,1.
- **Reset mid-burst.** Assert `reset` for 1 cycle while `write=1` and input FIFOs are non-empty → `write=0` and `read=0` during reset. After release, granting restarts from input 0.
